// File: rtl/video_mode_ctrl.sv
// Input video mode detector and lock controller: classifies incoming frames, locks after
// a run of matching frames, and hands the new mode to the output side via req/ack.
// Optional diagnostic counters on status are built when VIDEO_MODE_CTRL_STATUS_EN is defined.
module video_mode_ctrl #(
    parameter int          STABLE_FRAMES = 4,
    parameter logic [31:0] FRAME_TIMEOUT = 32'd4_000_000,
    parameter int          LEN_TOL       = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_strobe,
    input  logic [23:0] timing_info,
    input  logic        input_lost,
    input  logic        user_line_doubler,
    input  logic        user_test_pattern,
    input  logic        reconf_ack,
    output logic        line_doubler,
    output logic        generate_video,
    output logic        generate_timing,
    output logic [1:0]  mode,
    output logic        locked,
    output logic        reconf_req,
    output logic [23:0] status,
    output logic [1:0]  debug_state,
    output logic [3:0]  debug_match_cnt
);

    typedef enum logic [1:0] {
        NO_SIGNAL = 2'd0,
        ACQUIRE   = 2'd1,
        RECONF    = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    localparam logic [11:0] TOL      = 12'(LEN_TOL);
    localparam logic [3:0]  LOCK_CNT = 4'(STABLE_FRAMES - 1);

    state_t      state, state_n;
    logic [3:0]  match_cnt, match_cnt_n;
    logic [1:0]  ref_cls, ref_cls_n;
    logic [11:0] ref_len, ref_len_n;
    logic [31:0] to_cnt;

    logic [1:0]  cur_cls;
    logic [11:0] cur_len;
    logic [11:0] len_diff;
    logic [3:0]  cnt_inc;
    logic        frame_match;
    logic        timeout_hit;

    function automatic logic [1:0] classify(input logic [11:0] lines);
        case (lines)
            12'd262: classify = 2'd2;
            12'd524: classify = 2'd0;
            12'd624: classify = 2'd1;
            default: classify = 2'd3;
        endcase
    endfunction

    assign cur_cls     = classify(timing_info[11:0]);
    assign cur_len     = timing_info[23:12];
    assign len_diff    = (cur_len >= ref_len) ? (cur_len - ref_len) : (ref_len - cur_len);
    assign frame_match = (cur_cls == ref_cls) && (cur_cls != 2'd3) && (len_diff <= TOL);
    assign cnt_inc     = match_cnt + 4'd1;
    assign timeout_hit = (to_cnt >= FRAME_TIMEOUT);

    // The reference class/length is only replaced by a non-matching frame, so a slow
    // drift in line length is judged against the frame that started the run.
    always_comb begin
        state_n     = state;
        match_cnt_n = match_cnt;
        ref_cls_n   = ref_cls;
        ref_len_n   = ref_len;
        if (input_lost) begin
            state_n = NO_SIGNAL;
        end else if (timeout_hit && !frame_strobe) begin
            state_n = NO_SIGNAL;
        end else begin
            case (state)
                NO_SIGNAL: begin
                    if (frame_strobe) begin
                        state_n   = ACQUIRE;
                        ref_cls_n = cur_cls;
                        ref_len_n = cur_len;
                    end
                end
                ACQUIRE: begin
                    if (frame_strobe) begin
                        if (frame_match) begin
                            if (cnt_inc >= LOCK_CNT) state_n = RECONF;
                            else                     match_cnt_n = cnt_inc;
                        end else begin
                            match_cnt_n = 4'd0;
                            ref_cls_n   = cur_cls;
                            ref_len_n   = cur_len;
                        end
                    end
                end
                RECONF: begin
                    if (reconf_ack) state_n = LOCKED;
                end
                LOCKED: begin
                    if (frame_strobe && !frame_match) begin
                        state_n   = ACQUIRE;
                        ref_cls_n = cur_cls;
                        ref_len_n = cur_len;
                    end else if (user_line_doubler != line_doubler) begin
                        state_n = RECONF;
                    end
                end
                default: state_n = NO_SIGNAL;
            endcase
        end
        if (state_n != ACQUIRE) match_cnt_n = 4'd0;
    end

    // reconf_req rises together with RECONF entry and stays high until the cycle after
    // reconf_ack is sampled in RECONF; an ack seen in any other state has no effect.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= NO_SIGNAL;
            match_cnt       <= 4'd0;
            ref_cls         <= 2'd3;
            ref_len         <= 12'd0;
            to_cnt          <= 32'd0;
            mode            <= 2'd3;
            line_doubler    <= 1'b0;
            locked          <= 1'b0;
            reconf_req      <= 1'b0;
            generate_video  <= 1'b1;
            generate_timing <= 1'b1;
        end else begin
            state           <= state_n;
            match_cnt       <= match_cnt_n;
            ref_cls         <= ref_cls_n;
            ref_len         <= ref_len_n;
            if (frame_strobe)                  to_cnt <= 32'd0;
            else if (to_cnt != 32'hFFFF_FFFF)  to_cnt <= to_cnt + 32'd1;
            locked          <= (state_n == LOCKED);
            reconf_req      <= (state_n == RECONF);
            generate_timing <= (state_n != LOCKED);
            generate_video  <= (state_n == LOCKED) ? user_test_pattern : 1'b1;
            if (state_n == RECONF && state != RECONF) begin
                mode         <= ref_cls;
                line_doubler <= user_line_doubler;
            end
        end
    end

    assign debug_state     = state;
    assign debug_match_cnt = match_cnt;

`ifdef VIDEO_MODE_CTRL_STATUS_EN
    logic [7:0]  loss_cnt;
    logic [11:0] frame_cnt;

    // A lock loss is leaving LOCKED for anything but a reconfiguration.
    always_ff @(posedge clock) begin
        if (!reset) begin
            loss_cnt  <= 8'd0;
            frame_cnt <= 12'd0;
        end else begin
            if (frame_strobe) frame_cnt <= frame_cnt + 12'd1;
            if (state == LOCKED && (state_n == NO_SIGNAL || state_n == ACQUIRE) &&
                loss_cnt != 8'hFF)
                loss_cnt <= loss_cnt + 8'd1;
        end
    end

    assign status = {loss_cnt, frame_cnt, 2'b00, debug_state};
`else
    assign status = 24'd0;
`endif

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Bench for video_mode_ctrl: table of per-cycle input/expected-output records run through
// an expected-value queue, plus hand-written reset-in-RECONF and frame-timeout sequences.
module tb_video_mode_ctrl;

  localparam logic [31:0] TO = 32'd200;
  localparam int NS = 0;
  localparam int AQ = 1;
  localparam int RC = 2;
  localparam int LK = 3;

  typedef struct {
    logic        rst;
    logic        strobe;
    logic [11:0] len;
    logic [11:0] cnt;
    logic        lost;
    logic        udbl;
    logic        utp;
    logic        ack;
    logic [1:0]  st;
    logic [3:0]  mc;
    logic        lk;
    logic [1:0]  md;
    logic        rr;
    logic        gt;
    logic        gv;
    logic        ld;
  } vec_t;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        frame_strobe;
  logic [23:0] timing_info;
  logic        input_lost;
  logic        user_line_doubler;
  logic        user_test_pattern;
  logic        reconf_ack;
  logic        line_doubler;
  logic        generate_video;
  logic        generate_timing;
  logic [1:0]  mode;
  logic        locked;
  logic        reconf_req;
  logic [23:0] status;
  logic [1:0]  debug_state;
  logic [3:0]  debug_match_cnt;

  video_mode_ctrl #(
    .STABLE_FRAMES(4),
    .FRAME_TIMEOUT(TO),
    .LEN_TOL(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .frame_strobe(frame_strobe),
    .timing_info(timing_info),
    .input_lost(input_lost),
    .user_line_doubler(user_line_doubler),
    .user_test_pattern(user_test_pattern),
    .reconf_ack(reconf_ack),
    .line_doubler(line_doubler),
    .generate_video(generate_video),
    .generate_timing(generate_timing),
    .mode(mode),
    .locked(locked),
    .reconf_req(reconf_req),
    .status(status),
    .debug_state(debug_state),
    .debug_match_cnt(debug_match_cnt)
  );

  // scoreboard
  logic [36:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [11:0] fr_m   = 12'd0;
  logic [7:0]  ll_m   = 8'd0;
  logic [1:0]  prev_st = 2'd0;
  vec_t        tbl[$];

  function automatic vec_t mk(input int rst, input int strobe, input int len, input int cnt,
                              input int lost, input int udbl, input int utp, input int ack,
                              input int st, input int mc, input int lk, input int md,
                              input int rr, input int gt, input int gv, input int ld);
    vec_t r;
    r.rst = rst[0];   r.strobe = strobe[0]; r.len = len[11:0]; r.cnt = cnt[11:0];
    r.lost = lost[0]; r.udbl = udbl[0];     r.utp = utp[0];    r.ack = ack[0];
    r.st = st[1:0];   r.mc = mc[3:0];       r.lk = lk[0];      r.md = md[1:0];
    r.rr = rr[0];     r.gt = gt[0];         r.gv = gv[0];      r.ld = ld[0];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] outs_now();
    return {debug_state, debug_match_cnt, locked, mode, reconf_req, generate_timing,
            generate_video, line_doubler};
  endfunction

  // driver: one vector per clock, expected pushed at drive time, popped after the edge
  task automatic apply(input vec_t v, input string name);
    logic [23:0] exp_status;
    logic [36:0] exp_w;
    logic [36:0] act_w;
    @(negedge clock);
    reset             = v.rst;
    frame_strobe      = v.strobe;
    timing_info       = {v.len, v.cnt};
    input_lost        = v.lost;
    user_line_doubler = v.udbl;
    user_test_pattern = v.utp;
    reconf_ack        = v.ack;
    if (!v.rst) begin
      fr_m = 12'd0;
      ll_m = 8'd0;
    end else begin
      if (v.strobe) fr_m = fr_m + 12'd1;
      if (prev_st == 2'd3 && v.st <= 2'd1 && ll_m != 8'hFF) ll_m = ll_m + 8'd1;
    end
    prev_st = v.st;
`ifdef VIDEO_MODE_CTRL_STATUS_EN
    exp_status = {ll_m, fr_m, 2'b00, v.st};
`else
    exp_status = 24'd0;
`endif
    exp_w = {v.st, v.mc, v.lk, v.md, v.rr, v.gt, v.gv, v.ld, exp_status};
    exp_q.push_back(exp_w);
    @(posedge clock);
    #1;
    act_w = {outs_now(), status};
    check(name, {27'd0, act_w}, {27'd0, exp_q.pop_front()});
  endtask

  task automatic idle();
    @(negedge clock);
    frame_strobe = 1'b0;
    input_lost   = 1'b0;
    reconf_ack   = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int idle_cnt;
    reset = 1'b0; frame_strobe = 1'b0; timing_info = 24'd0; input_lost = 1'b0;
    user_line_doubler = 1'b0; user_test_pattern = 1'b0; reconf_ack = 1'b0;
    repeat (3) @(posedge clock);

    // rst strb len cnt lost udbl utp ack | st mc lk md rr gt gv ld
    tbl.push_back(mk(0,0,   0,  0,0,0,0,0, NS,0,0,3,0,1,1,0));
    // NTSC acquire and lock
    tbl.push_back(mk(1,1,1716,524,0,0,0,0, AQ,0,0,3,0,1,1,0));
    tbl.push_back(mk(1,1,1716,524,0,0,0,0, AQ,1,0,3,0,1,1,0));
    tbl.push_back(mk(1,1,1716,524,0,0,0,0, AQ,2,0,3,0,1,1,0));
    tbl.push_back(mk(1,1,1716,524,0,0,0,0, RC,0,0,0,1,1,1,0));
    tbl.push_back(mk(1,0,   0,  0,0,0,0,0, RC,0,0,0,1,1,1,0));
    tbl.push_back(mk(1,0,   0,  0,0,0,0,1, LK,0,1,0,0,0,0,0));
    tbl.push_back(mk(1,0,   0,  0,0,0,0,0, LK,0,1,0,0,0,0,0));
    tbl.push_back(mk(1,0,   0,  0,0,0,0,1, LK,0,1,0,0,0,0,0));
    tbl.push_back(mk(1,0,   0,  0,0,0,1,0, LK,0,1,0,0,0,1,0));
    tbl.push_back(mk(1,0,   0,  0,0,0,0,0, LK,0,1,0,0,0,0,0));
    tbl.push_back(mk(1,1,1716,524,0,0,0,0, LK,0,1,0,0,0,0,0));
    // switch to 240p while locked
    tbl.push_back(mk(1,1,1716,262,0,0,0,0, AQ,0,0,0,0,1,1,0));
    tbl.push_back(mk(1,1,1716,262,0,0,0,0, AQ,1,0,0,0,1,1,0));
    tbl.push_back(mk(1,1,1716,262,0,0,0,0, AQ,2,0,0,0,1,1,0));
    tbl.push_back(mk(1,1,1716,262,0,0,0,0, RC,0,0,2,1,1,1,0));
    tbl.push_back(mk(1,1,1716,262,0,0,0,0, RC,0,0,2,1,1,1,0));
    tbl.push_back(mk(1,0,   0,  0,0,0,0,1, LK,0,1,2,0,0,0,0));
    // PAL with length drift inside tolerance, then outside
    tbl.push_back(mk(1,1,1716,624,0,0,0,0, AQ,0,0,2,0,1,1,0));
    tbl.push_back(mk(1,1,1718,624,0,0,0,0, AQ,1,0,2,0,1,1,0));
    tbl.push_back(mk(1,1,1714,624,0,0,0,0, AQ,2,0,2,0,1,1,0));
    tbl.push_back(mk(1,1,1717,624,0,0,0,0, RC,0,0,1,1,1,1,0));
    tbl.push_back(mk(1,0,   0,  0,0,0,0,1, LK,0,1,1,0,0,0,0));
    tbl.push_back(mk(1,1,1716,624,0,0,0,0, LK,0,1,1,0,0,0,0));
    tbl.push_back(mk(1,1,1720,624,0,0,0,0, AQ,0,0,1,0,1,1,0));
    tbl.push_back(mk(1,1,1716,624,0,0,0,0, AQ,0,0,1,0,1,1,0));
    tbl.push_back(mk(1,1,1718,624,0,0,0,0, AQ,1,0,1,0,1,1,0));
    tbl.push_back(mk(1,1,1721,624,0,0,0,0, AQ,0,0,1,0,1,1,0));
    tbl.push_back(mk(1,1,1716,500,0,0,0,0, AQ,0,0,1,0,1,1,0));
    tbl.push_back(mk(1,1,1716,500,0,0,0,0, AQ,0,0,1,0,1,1,0));
    tbl.push_back(mk(1,1,1716,524,0,0,0,0, AQ,0,0,1,0,1,1,0));
    tbl.push_back(mk(1,1,1713,524,0,0,0,0, AQ,0,0,1,0,1,1,0));
    tbl.push_back(mk(1,1,1715,524,0,0,0,0, AQ,1,0,1,0,1,1,0));
    // input_lost beats frame_strobe
    tbl.push_back(mk(1,1,1715,524,1,0,0,0, NS,0,0,1,0,1,1,0));
    tbl.push_back(mk(1,1,1716,524,1,0,0,0, NS,0,0,1,0,1,1,0));
    tbl.push_back(mk(1,1,1716,524,0,0,0,0, AQ,0,0,1,0,1,1,0));
    tbl.push_back(mk(1,1,1716,524,0,0,0,0, AQ,1,0,1,0,1,1,0));
    tbl.push_back(mk(1,1,1716,524,0,0,0,0, AQ,2,0,1,0,1,1,0));
    tbl.push_back(mk(1,1,1716,524,0,0,0,0, RC,0,0,0,1,1,1,0));
    tbl.push_back(mk(1,0,   0,  0,0,0,0,0, RC,0,0,0,1,1,1,0));
    tbl.push_back(mk(1,0,   0,  0,0,0,0,1, LK,0,1,0,0,0,0,0));
    // line doubler toggles while locked; ack on the RECONF entry cycle
    tbl.push_back(mk(1,0,   0,  0,0,1,0,0, RC,0,0,0,1,1,1,1));
    tbl.push_back(mk(1,0,   0,  0,0,1,0,1, LK,0,1,0,0,0,0,1));
    tbl.push_back(mk(1,0,   0,  0,0,1,0,0, LK,0,1,0,0,0,0,1));
    tbl.push_back(mk(1,0,   0,  0,0,0,0,0, RC,0,0,0,1,1,1,0));
    tbl.push_back(mk(1,0,   0,  0,0,0,0,1, LK,0,1,0,0,0,0,0));
    tbl.push_back(mk(1,0,   0,  0,1,0,0,0, NS,0,0,0,0,1,1,0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // reset while in RECONF with ack pending
    apply(mk(1,1,1716,624,0,0,0,0, AQ,0,0,0,0,1,1,0), "rst_rc_a0");
    apply(mk(1,1,1716,624,0,0,0,0, AQ,1,0,0,0,1,1,0), "rst_rc_a1");
    apply(mk(1,1,1716,624,0,0,0,0, AQ,2,0,0,0,1,1,0), "rst_rc_a2");
    apply(mk(1,1,1716,624,0,0,0,0, RC,0,0,1,1,1,1,0), "rst_rc_enter");
    apply(mk(0,0,   0,  0,0,0,0,1, NS,0,0,3,0,1,1,0), "rst_rc_drop");
    apply(mk(1,0,   0,  0,0,0,0,1, NS,0,0,3,0,1,1,0), "rst_rc_ack_ignored");

    // frame timeout from LOCKED
    apply(mk(1,1,1716,624,0,0,0,0, AQ,0,0,3,0,1,1,0), "to_a0");
    apply(mk(1,1,1716,624,0,0,0,0, AQ,1,0,3,0,1,1,0), "to_a1");
    apply(mk(1,1,1716,624,0,0,0,0, AQ,2,0,3,0,1,1,0), "to_a2");
    apply(mk(1,1,1716,624,0,0,0,0, RC,0,0,1,1,1,1,0), "to_rc");
    apply(mk(1,0,   0,  0,0,0,0,1, LK,0,1,1,0,0,0,0), "to_lock");
    idle_cnt = 1;
    for (int k = 0; k < 1000; k++) begin
      idle();
      idle_cnt = idle_cnt + 1;
      if (debug_state == 2'd0) break;
    end
    check("timeout_latency", 64'(idle_cnt), 64'(TO + 32'd1));
    check("timeout_outputs", {51'd0, outs_now()}, {51'd0, 2'd0, 4'd0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0});
    if (ll_m != 8'hFF) ll_m = ll_m + 8'd1;
    prev_st = 2'd0;
    apply(mk(1,1,1716,624,0,0,0,0, AQ,0,0,1,0,1,1,0), "to_recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
